// File: rtl/dlx_bus_pkg.sv
// -----------------------------------------------------------------------------
// dlx_bus_pkg
// Shared definitions for the SIMD DLX internal bus arbiter:
//   - arb_state_t   : arbiter FSM states (IDLE, GRANT, TURN)
//   - DEFAULT_DW    : default bus width (32)
//   - DEFAULT_N_REQ : default number of requesters (4)
//   - clog2()       : ceiling log2, usable in parameter expressions
// -----------------------------------------------------------------------------
package dlx_bus_pkg;

  localparam int DEFAULT_DW    = 32;
  localparam int DEFAULT_N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the request vector upward from
// i_ptr (inclusive), wrapping from N_REQ-1 back to 0, and reports the first
// requester found.
// Ports:
//   i_req    [N_REQ-1:0] : request vector
//   i_ptr    [IW-1:0]    : search start index (always < N_REQ)
//   o_onehot [N_REQ-1:0] : one-hot winner (zero when nothing requested)
//   o_idx    [IW-1:0]    : winner index (zero when nothing requested)
//   o_any                : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import dlx_bus_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  localparam int IW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    logic [IW-1:0] w_cand;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = i_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_any && i_req[w_cand]) begin
        o_any            = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
      // Explicit wrap so non-power-of-two N_REQ never indexes past the end.
      w_cand = (w_cand == IW'(N_REQ - 1)) ? '0 : w_cand + 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin owner arbiter for the shared internal data bus of the SIMD DLX
// core. One owner at a time drives the bus; every ownership change inserts a
// single dead turnaround cycle with all buffer enables low. The winning data
// is registered onto BUS with a one-cycle latency.
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN
//   defined   -> a hold counter forces release after MAX_HOLD data beats
//   undefined -> no counter; the owner keeps the bus until LAST or REQ drop
//
// Ports:
//   CLK        : clock, all state changes on the rising edge
//   RESET      : synchronous active-high reset
//   REQ   [N]  : level request per requester, held until granted
//   LAST  [N]  : owner's final data beat this cycle
//   DIN   [N*DW]: requester data, slice i = DIN[i*DW +: DW]
//   GNT   [N]  : one-hot grant, zero outside GRANT
//   OE    [N]  : bus buffer enables, identical to GNT
//   OWNER [IW] : index of the current / most recent owner
//   BUS   [DW] : registered winning data
//   BUS_VALID  : BUS holds a beat captured on the previous edge
// -----------------------------------------------------------------------------
module bus_arbiter
  import dlx_bus_pkg::*;
#(
  parameter int N_REQ    = DEFAULT_N_REQ,
  parameter int DW       = DEFAULT_DW,
  parameter int MAX_HOLD = 8,
  localparam int IW      = clog2(N_REQ)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ-1:0]    LAST,
  input  logic [N_REQ*DW-1:0] DIN,
  output logic [N_REQ-1:0]    GNT,
  output logic [N_REQ-1:0]    OE,
  output logic [IW-1:0]       OWNER,
  output logic [DW-1:0]       BUS,
  output logic                BUS_VALID
);

  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("bus_arbiter: N_REQ must be 2..8 and MAX_HOLD at least 1");
  end

  arb_state_t       r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_ptr;
  logic [DW-1:0]    r_bus;
  logic             r_bus_valid;

  logic [DW-1:0]    w_din [N_REQ];
  logic [N_REQ-1:0] w_pick_onehot;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_own_req;
  logic             w_own_last;
  logic             w_hold_done;
  logic             w_release;
  logic [IW-1:0]    w_ptr_after;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_din_slice
    assign w_din[gi] = DIN[gi*DW +: DW];
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_req    (REQ),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Only the owner's REQ/LAST matter during GRANT.
  assign w_own_req   = REQ[r_owner];
  assign w_own_last  = LAST[r_owner];
  assign w_ptr_after = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = clog2(MAX_HOLD + 1);
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_inc;

  assign w_hold_inc  = r_hold + 1'b1;
  // This beat is the MAX_HOLD-th one: release together with it.
  assign w_hold_done = w_own_req && (w_hold_inc == HW'(MAX_HOLD));
`else
  assign w_hold_done = 1'b0;
`endif

  // LAST without REQ still releases, just without a beat.
  assign w_release = !w_own_req || w_own_last || w_hold_done;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_bus       <= '0;
      r_bus_valid <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      r_hold      <= '0;
`endif
    end else begin
      case (r_state)
        // IDLE and TURN both grant from the current pointer when anyone
        // asks; TURN's pointer has already moved past the previous owner.
        ST_IDLE, ST_TURN: begin
          r_bus_valid <= 1'b0;
          if (w_pick_any) begin
            r_state <= ST_GRANT;
            r_gnt   <= w_pick_onehot;
            r_owner <= w_pick_idx;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold  <= '0;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_GRANT: begin
          if (w_own_req) begin
            r_bus       <= w_din[r_owner];
            r_bus_valid <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold      <= w_hold_inc;
`endif
          end else begin
            r_bus_valid <= 1'b0;
          end
          if (w_release) begin
            r_state <= ST_TURN;
            r_gnt   <= '0;
            r_ptr   <= w_ptr_after;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_gnt       <= '0;
          r_bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign GNT       = r_gnt;
  assign OE        = r_gnt;
  assign OWNER     = r_owner;
  assign BUS       = r_bus;
  assign BUS_VALID = r_bus_valid;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (N_REQ=4, DW=32, MAX_HOLD=8).
// Follows BUS_ARB_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 8;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  last;
  logic [DW-1:0] din_a [N];
  logic [N*DW-1:0] din;
  logic [N-1:0]  gnt;
  logic [N-1:0]  oe;
  logic [1:0]    owner;
  logic [DW-1:0] bus;
  logic          bus_valid;

  int n_cmp = 0;
  int n_bad = 0;

  assign din = {din_a[3], din_a[2], din_a[1], din_a[0]};

  always #5 clk = ~clk;

  bus_arbiter #(
    .N_REQ    (N),
    .DW       (DW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .REQ       (req),
    .LAST      (last),
    .DIN       (din),
    .GNT       (gnt),
    .OE        (oe),
    .OWNER     (owner),
    .BUS       (bus),
    .BUS_VALID (bus_valid)
  );

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic [N-1:0]  exp_gnt;
    logic [1:0]    exp_owner;
    logic [DW-1:0] exp_bus;
    logic          exp_valid;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                              input logic [3:0] g, input logic [1:0] o,
                              input logic [31:0] b, input logic v);
    vec_t t;
    t.rst = r; t.req = rq; t.last = ls; t.exp_gnt = g;
    t.exp_owner = o; t.exp_bus = b; t.exp_valid = v;
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: "who owns the bus" as an integer (-1 = nobody).
  // A released owner always leaves one cycle with no owner, and a cycle with
  // no owner grants the first requester at or after ptr.
  // ---------------------------------------------------------------------------
  int            m_owner;
  int            m_last_owner;
  int            m_ptr;
  int            m_hold;
  logic [DW-1:0] m_bus;
  logic          m_valid;

  task automatic model_edge();
    if (rst) begin
      m_owner = -1; m_last_owner = 0; m_ptr = 0; m_hold = 0;
      m_bus = '0; m_valid = 1'b0;
    end else if (m_owner >= 0) begin
      bit done;
      done = !req[m_owner] || last[m_owner];
      if (req[m_owner]) begin
        m_bus   = din_a[m_owner];
        m_valid = 1'b1;
        m_hold  = m_hold + 1;
        if (TO && m_hold == MAX_HOLD) done = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (done) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
      m_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_last_owner = c; m_hold = 0;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                       input logic [31:0] eb, input logic ev);
    n_cmp++;
    if (gnt !== eg || oe !== eg || owner !== eo || bus !== eb || bus_valid !== ev) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b oe=%b owner=%0d bus=%h valid=%b, want gnt=%b oe=%b owner=%0d bus=%h valid=%b",
               tag, gnt, oe, owner, bus, bus_valid, eg, eg, eo, eb, ev);
    end else begin
      $display("ok   %s: gnt=%b owner=%0d bus=%h valid=%b", tag, gnt, owner, bus, bus_valid);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int beats;
    int held;
    bit released;

    din_a[0] = 32'hC0DE_0000;
    din_a[1] = 32'h1111_1111;
    din_a[2] = 32'hDEAD_BEEF;
    din_a[3] = 32'h3333_3333;

    // Single request on 2 (LAST on 3rd beat), then reset, then 4-way contention.
    tbl[0]  = mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 32'h0,         0);
    tbl[1]  = mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 32'hDEAD_BEEF, 1);
    tbl[2]  = mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 32'hDEAD_BEEF, 1);
    tbl[3]  = mk(0, 4'b0100, 4'b0100, 4'b0000, 2, 32'hDEAD_BEEF, 1);
    tbl[4]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 2, 32'hDEAD_BEEF, 0);
    tbl[5]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 2, 32'hDEAD_BEEF, 0);
    tbl[6]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0,         0);
    tbl[7]  = mk(0, 4'b1111, 4'b1111, 4'b0001, 0, 32'h0,         0);
    tbl[8]  = mk(0, 4'b1111, 4'b1111, 4'b0000, 0, 32'hC0DE_0000, 1);
    tbl[9]  = mk(0, 4'b1111, 4'b1111, 4'b0010, 1, 32'hC0DE_0000, 0);
    tbl[10] = mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 32'h1111_1111, 1);
    tbl[11] = mk(0, 4'b1111, 4'b1111, 4'b0100, 2, 32'h1111_1111, 0);
    tbl[12] = mk(0, 4'b1111, 4'b1111, 4'b0000, 2, 32'hDEAD_BEEF, 1);
    tbl[13] = mk(0, 4'b1111, 4'b1111, 4'b1000, 3, 32'hDEAD_BEEF, 0);
    tbl[14] = mk(0, 4'b1111, 4'b1111, 4'b0000, 3, 32'h3333_3333, 1);
    tbl[15] = mk(0, 4'b1111, 4'b1111, 4'b0001, 0, 32'h3333_3333, 0);
    tbl[16] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h3333_3333, 0);
    tbl[17] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h3333_3333, 0);

    // Power-on reset, two edges.
    rst = 1'b1; req = '0; last = '0;
    step();
    step();
    check("reset_state", 4'b0000, 2'd0, 32'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; last = tbl[i].last;
      step();
      check($sformatf("vec%0d", i), tbl[i].exp_gnt, tbl[i].exp_owner,
            tbl[i].exp_bus, tbl[i].exp_valid);
    end
    rst = 1'b0;

    // Reset in the middle of owner 2's burst.
    do_reset();
    req = 4'b0100;
    step();
    check("midrst_grant", 4'b0100, 2'd2, 32'h0, 1'b0);
    step();
    step();
    check("midrst_beat", 4'b0100, 2'd2, 32'hDEAD_BEEF, 1'b1);
    rst = 1'b1;
    step();
    check("midrst_cleared", 4'b0000, 2'd0, 32'h0, 1'b0);
    rst = 1'b0; req = 4'b0001;
    step();
    check("midrst_regrant0", 4'b0001, 2'd0, 32'h0, 1'b0);

    // Long hold on requester 1 without LAST.
    do_reset();
    req = 4'b0010; last = '0;
    step();
    check("hold_grant", 4'b0010, 2'd1, 32'h0, 1'b0);
    beats = 0; held = 0; released = 1'b0;
    if (TO) begin
      for (int i = 0; i < 40; i++) begin
        step();
        if (bus_valid) beats++;
        if (gnt == 4'b0000) begin
          released = 1'b1;
          break;
        end
      end
      check_val("timeout_beats", beats, MAX_HOLD);
      check_val("timeout_released", int'(released), 1);
      step();
      check("timeout_regrant", 4'b0010, 2'd1, 32'h1111_1111, 1'b0);
    end else begin
      for (int i = 0; i < 32; i++) begin
        step();
        if (gnt == 4'b0010 && oe == 4'b0010 && bus_valid && bus == 32'h1111_1111) held++;
      end
      check_val("no_timeout_hold32", held, 32);
      check("no_timeout_still_owner", 4'b0010, 2'd1, 32'h1111_1111, 1'b1);
    end

    // Owner 0 drops REQ after two beats while requester 3 waits.
    do_reset();
    req = 4'b0001;
    step();
    check("drop_grant0", 4'b0001, 2'd0, 32'h0, 1'b0);
    step();
    step();
    check("drop_beat2", 4'b0001, 2'd0, 32'hC0DE_0000, 1'b1);
    req = 4'b1000;
    step();
    check("drop_turn", 4'b0000, 2'd0, 32'hC0DE_0000, 1'b0);
    step();
    check("drop_grant3", 4'b1000, 2'd3, 32'hC0DE_0000, 1'b0);

    // Randomised traffic against the reference model.
    do_reset();
    rst = 1'b1;
    model_edge();
    step();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] eg;
      rst  = ($urandom_range(0, 59) == 0);
      req  = N'($urandom);
      last = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      for (int j = 0; j < N; j++) din_a[j] = $urandom;
      model_edge();
      step();
      eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      check($sformatf("rand%0d", i), eg, 2'(m_last_owner), m_bus, m_valid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
